control_unit_p: RTL and testbench
=================================

# control_unit_p

Parametrised multi-cycle control unit for the lab CPU datapath. It holds the instruction register and runs a fetch/execute/write-back/PC-update sequence, with ready/valid-style waits on instruction memory and the ALU. Compared with the fixed 16-bit/4-register controller, it adds a configurable register count and widths, a latched zero flag, a conditional branch, a halt state and illegal-opcode reporting. It sits between instruction RAM, the register group, the ALU and the PC.

## Interface
Parameters:
- INS_W, 16, instruction width; must satisfy 4 + 2*RD_W + ADDR_W <= INS_W
- ADDR_W, 8, offset/immediate field width (IR[ADDR_W-1:0])
- REG_N, 4, number of registers (power of 2, >= 2); RD_W = clog2(REG_N)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  run enable; sampled in IDLE and at end of each instruction
- ins  in  INS_W  instruction word from RAM
- ins_valid  in  1  ins is valid; honoured only in WAIT_IR
- alu_done  in  1  ALU result ready; honoured only in WAIT_ALU
- alu_zero  in  1  ALU zero result; sampled with alu_done
- fetch_req  out  1  one-cycle instruction read request
- alu_start  out  1  one-cycle ALU start pulse
- alu_func  out  3  ALU function decoded from IR
- alu_in_sel  out  1  1 = ALU B input from offset_addr (immediate)
- reg_en  out  REG_N  one-hot register write enable, one-cycle
- rs_sel  out  RD_W  source register select = IR rs field
- offset_addr  out  ADDR_W  IR[ADDR_W-1:0]
- en_pc_pulse  out  1  one-cycle PC update strobe
- pc_ctrl  out  2  00 hold, 01 increment, 10 load offset_addr
- halted  out  1  high while in HALT
- illegal  out  1  one-cycle pulse on undefined opcode

## Operation
- IR fields: opcode = IR[INS_W-1 -: 4]; rd = next RD_W bits; rs = next RD_W bits; offset = IR[ADDR_W-1:0].
- Opcodes: 0 NOP; 1 ADD (func 000); 2 SUB (001); 3 AND (010); 4 OR (011); 5 LDI (func 100, alu_in_sel=1); 6 JMP; 7 JZ; F HLT; 8-E illegal, executed as NOP.
- alu_func, alu_in_sel, rs_sel and offset_addr are combinational from IR. Non-ALU opcodes give func 000 and sel 0.
- Z flag: updated from alu_zero only on alu_done in WAIT_ALU. Reset value 0.
- States:
  - IDLE: if en, go to FETCH.
  - FETCH: fetch_req=1, go to WAIT_IR.
  - WAIT_IR: on ins_valid, IR <= ins and go to EXEC.
  - EXEC:
    - ALU ops (1-5): alu_start=1, go to WAIT_ALU.
    - HLT: go to HALT.
    - Illegal: illegal=1, go to UPDATE_PC.
    - Others: go to UPDATE_PC.
  - WAIT_ALU: on alu_done, latch Z and go to WRITE.
  - WRITE: reg_en[rd]=1, go to UPDATE_PC.
  - UPDATE_PC: en_pc_pulse=1. pc_ctrl=10 for JMP, and for JZ when Z=1; otherwise 01. Next state is FETCH if en=1, else IDLE.
  - HALT: halted=1. Only rst leaves HALT; en is ignored.
- pc_ctrl is 00 in every state except UPDATE_PC.

## Timing
- Reset (synchronous): state=IDLE, IR=0, Z=0. All outputs are 0, including pulses, reg_en, pc_ctrl, halted, and the decoded outputs (IR=0).
- Zero-wait ALU instruction, with en high at cycle 0 in IDLE:
  - c1 fetch_req
  - c2 ins_valid
  - c3 alu_start
  - c4 alu_done
  - c5 reg_en
  - c6 en_pc_pulse
  - c7 fetch_req of the next instruction
- Throughput: ALU op 6 cycles per instruction; non-ALU op 4 cycles.
- Each wait state adds exactly one cycle. Outputs hold steady while waiting.
- ins_valid outside WAIT_IR and alu_done outside WAIT_ALU have no effect, including stray pulses coincident with state entry.
- en deasserted mid-instruction: the current instruction completes through UPDATE_PC, then the FSM goes to IDLE.
- rst wins over every other input. rst asserted mid-instruction aborts it with no further pulses, and the FSM is in IDLE the cycle after.
- JZ tests Z as latched by the most recent completed ALU op. The JZ instruction itself does not change Z.

## Test plan
- Reset: assert rst 2 cycles with en=1 -> all outputs 0 and the FSM in IDLE; fetch_req appears the cycle after rst drops.
- ADD r2 (ins=16'h1800, zero-wait) -> fetch_req c1, alu_start c3 with alu_func=000, reg_en=4'b0100 c5, en_pc_pulse with pc_ctrl=01 c6, next fetch_req c7.
- Branch:
  - SUB with alu_zero=1, then JZ ins=16'h703C -> pc_ctrl=10 and offset_addr=8'h3C on en_pc_pulse.
  - Repeat with alu_zero=0 -> pc_ctrl=01.
  - JMP 16'h6012 -> pc_ctrl=10, offset_addr=8'h12.
- Waits and strays:
  - ins_valid delayed 3 cycles and alu_done delayed 5 -> instruction takes 14 cycles and outputs are stable throughout.
  - alu_done pulsed during WAIT_IR -> ignored, and Z is unchanged.
- HLT and illegal:
  - ins=16'hF000 -> halted=1; no fetch_req for 20 cycles with en=1; rst clears halted.
  - ins=16'h9000 -> one illegal pulse, then pc_ctrl=01.
- Parameter and reset: instance with INS_W=20, ADDR_W=10, REG_N=8.
  - ADD rd=5 -> reg_en=8'b0010_0000.
  - rst asserted in WAIT_ALU -> no reg_en or en_pc_pulse follows, and the FSM is in IDLE next cycle.

Source files
------------

// File: rtl/control_unit_p.sv
// Multi-cycle control unit for the lab CPU datapath: instruction register,
// fetch/execute/write-back/PC-update sequencing, latched zero flag and halt.
//
// state     | meaning
// IDLE      | stopped, waiting for en
// FETCH     | one-cycle instruction read request
// WAIT_IR   | waiting for ins_valid, then latch IR
// EXEC      | decode; start ALU, halt, or flag an illegal opcode
// WAIT_ALU  | waiting for alu_done, then latch Z
// WRITE     | one-hot write enable to destination register
// UPDATE_PC | PC strobe with hold/increment/load select
// HALT      | parked until reset
module control_unit_p #(
  parameter int INS_W  = 16,
  parameter int ADDR_W = 8,
  parameter int REG_N  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [INS_W-1:0]         ins,
  input  logic                     ins_valid,
  input  logic                     alu_done,
  input  logic                     alu_zero,
  output logic                     fetch_req,
  output logic                     alu_start,
  output logic [2:0]               alu_func,
  output logic                     alu_in_sel,
  output logic [REG_N-1:0]         reg_en,
  output logic [$clog2(REG_N)-1:0] rs_sel,
  output logic [ADDR_W-1:0]        offset_addr,
  output logic                     en_pc_pulse,
  output logic [1:0]               pc_ctrl,
  output logic                     halted,
  output logic                     illegal
);

  localparam int RD_W = $clog2(REG_N);

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_IR,
    EXEC,
    WAIT_ALU,
    WRITE,
    UPDATE_PC,
    HALT
  } state_t;

  state_t            state, state_nxt;
  logic [INS_W-1:0]  ir;
  logic              z_flag;

  logic [3:0]        opcode;
  logic [RD_W-1:0]   rd;
  logic              is_alu_op;
  logic              is_illegal_op;

  assign opcode      = ir[INS_W-1 -: 4];
  assign rd          = ir[INS_W-5 -: RD_W];
  assign rs_sel      = ir[INS_W-5-RD_W -: RD_W];
  assign offset_addr = ir[ADDR_W-1:0];

  assign is_alu_op     = (opcode >= OP_ADD) && (opcode <= OP_LDI);
  assign is_illegal_op = (opcode >= 4'h8) && (opcode <= 4'hE);

  always_comb begin
    alu_func   = 3'b000;
    alu_in_sel = 1'b0;
    case (opcode)
      OP_ADD:  alu_func = 3'b000;
      OP_SUB:  alu_func = 3'b001;
      OP_AND:  alu_func = 3'b010;
      OP_OR:   alu_func = 3'b011;
      OP_LDI: begin
        alu_func   = 3'b100;
        alu_in_sel = 1'b1;
      end
      default: begin
        alu_func   = 3'b000;
        alu_in_sel = 1'b0;
      end
    endcase
  end

  // IR and Z only move in their own wait states, so strays elsewhere are inert.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ir     <= '0;
      z_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == WAIT_IR && ins_valid) begin
        ir <= ins;
      end
      if (state == WAIT_ALU && alu_done) begin
        z_flag <= alu_zero;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    fetch_req   = 1'b0;
    alu_start   = 1'b0;
    reg_en      = '0;
    en_pc_pulse = 1'b0;
    pc_ctrl     = PC_HOLD;
    halted      = 1'b0;
    illegal     = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_nxt = FETCH;
      end
      FETCH: begin
        fetch_req = 1'b1;
        state_nxt = WAIT_IR;
      end
      WAIT_IR: begin
        if (ins_valid) state_nxt = EXEC;
      end
      EXEC: begin
        if (is_alu_op) begin
          alu_start = 1'b1;
          state_nxt = WAIT_ALU;
        end else if (opcode == OP_HLT) begin
          state_nxt = HALT;
        end else begin
          illegal   = is_illegal_op;
          state_nxt = UPDATE_PC;
        end
      end
      WAIT_ALU: begin
        if (alu_done) state_nxt = WRITE;
      end
      WRITE: begin
        reg_en[rd] = 1'b1;
        state_nxt  = UPDATE_PC;
      end
      UPDATE_PC: begin
        en_pc_pulse = 1'b1;
        if (opcode == OP_JMP || (opcode == OP_JZ && z_flag)) begin
          pc_ctrl = PC_LOAD;
        end else begin
          pc_ctrl = PC_INC;
        end
        state_nxt = en ? FETCH : IDLE;
      end
      HALT: begin
        halted    = 1'b1;
        state_nxt = HALT;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_unit_p.sv
// Bench for control_unit_p: default instance for sequencing, branches, waits,
// strays, halt and illegal opcodes; a wide instance for parameters and abort.
module tb_control_unit_p;

  logic        clk;
  logic        rst, en, ins_valid, alu_done, alu_zero;
  logic [15:0] ins;
  logic        fetch_req, alu_start, alu_in_sel, en_pc_pulse, halted, illegal;
  logic [2:0]  alu_func;
  logic [3:0]  reg_en;
  logic [1:0]  rs_sel, pc_ctrl;
  logic [7:0]  offset_addr;

  logic        rst1, en1, ins_valid1, alu_done1, alu_zero1;
  logic [19:0] ins1;
  logic        fetch_req1, alu_start1, alu_in_sel1, en_pc_pulse1, halted1, illegal1;
  logic [2:0]  alu_func1;
  logic [7:0]  reg_en1;
  logic [2:0]  rs_sel1;
  logic [1:0]  pc_ctrl1;
  logic [9:0]  offset_addr1;

  int tests_run = 0;
  int fails = 0;

  control_unit_p dut0 (
    .clk(clk), .rst(rst), .en(en), .ins(ins), .ins_valid(ins_valid),
    .alu_done(alu_done), .alu_zero(alu_zero), .fetch_req(fetch_req),
    .alu_start(alu_start), .alu_func(alu_func), .alu_in_sel(alu_in_sel),
    .reg_en(reg_en), .rs_sel(rs_sel), .offset_addr(offset_addr),
    .en_pc_pulse(en_pc_pulse), .pc_ctrl(pc_ctrl), .halted(halted), .illegal(illegal)
  );

  control_unit_p #(.INS_W(20), .ADDR_W(10), .REG_N(8)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .ins(ins1), .ins_valid(ins_valid1),
    .alu_done(alu_done1), .alu_zero(alu_zero1), .fetch_req(fetch_req1),
    .alu_start(alu_start1), .alu_func(alu_func1), .alu_in_sel(alu_in_sel1),
    .reg_en(reg_en1), .rs_sel(rs_sel1), .offset_addr(offset_addr1),
    .en_pc_pulse(en_pc_pulse1), .pc_ctrl(pc_ctrl1), .halted(halted1), .illegal(illegal1)
  );

  wire [24:0] out0 = {fetch_req, alu_start, alu_func, alu_in_sel, reg_en, rs_sel,
                      offset_addr, en_pc_pulse, pc_ctrl, halted, illegal};
  wire [31:0] out1 = {fetch_req1, alu_start1, alu_func1, alu_in_sel1, reg_en1, rs_sel1,
                      offset_addr1, en_pc_pulse1, pc_ctrl1, halted1, illegal1};

  typedef struct {
    logic [3:0] reg_en;
    logic [1:0] pc;
    logic [7:0] off;
    logic [2:0] func;
    logic       insel;
    int         cycles;
  } exp_t;

  typedef struct {
    logic       fetch_c1;
    logic       alu_start;
    logic [2:0] func;
    logic       insel;
    logic       illegal_exec;
    logic       illegal_after;
    logic [3:0] reg_en;
    logic       pulse;
    logic [1:0] pc;
    logic [7:0] off;
    logic       halted;
    logic       next_fetch;
    logic       stable;
    int         cycles;
  } obs_t;

  exp_t sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction on dut0 starting in the cycle where fetch_req is visible.
  task automatic do_instr(input logic [15:0] w, input int ins_dly, input int alu_dly,
                          input bit zero, input bit strays, input bit drop_en, output obs_t o);
    logic [3:0] op;
    op = w[15:12];
    o = '{default: 0};
    o.stable   = 1'b1;
    o.fetch_c1 = fetch_req;
    if (drop_en) en = 1'b0;
    tick();
    o.cycles = 1;
    for (int i = 0; i < ins_dly; i++) begin
      if (strays) begin
        alu_done = 1'b1;
        alu_zero = 1'b0;
      end
      if (fetch_req || alu_start || en_pc_pulse || illegal || halted || (|reg_en) || (|pc_ctrl))
        o.stable = 1'b0;
      tick();
      o.cycles++;
    end
    alu_done  = 1'b0;
    ins       = w;
    ins_valid = 1'b1;
    tick();
    o.cycles++;
    ins_valid      = 1'b0;
    ins            = 16'hFFFF;
    o.alu_start    = alu_start;
    o.func         = alu_func;
    o.insel        = alu_in_sel;
    o.illegal_exec = illegal;
    if (op >= 4'h1 && op <= 4'h5) begin
      tick();
      o.cycles++;
      for (int i = 0; i < alu_dly; i++) begin
        if (strays) begin
          ins       = 16'h1C00;
          ins_valid = 1'b1;
        end
        if (fetch_req || alu_start || en_pc_pulse || illegal || halted || (|reg_en) ||
            (|pc_ctrl) || alu_func !== o.func || alu_in_sel !== o.insel)
          o.stable = 1'b0;
        tick();
        o.cycles++;
      end
      ins_valid = 1'b0;
      alu_done  = 1'b1;
      alu_zero  = zero;
      tick();
      o.cycles++;
      alu_done = 1'b0;
      o.reg_en = reg_en;
      tick();
      o.cycles++;
    end else if (op == 4'hF) begin
      tick();
      o.cycles++;
      o.halted = halted;
      return;
    end else begin
      tick();
      o.cycles++;
    end
    o.illegal_after = illegal;
    o.pulse         = en_pc_pulse;
    o.pc            = pc_ctrl;
    o.off           = offset_addr;
    for (int i = 0; i < 5 && !o.next_fetch; i++) begin
      tick();
      o.cycles++;
      if (fetch_req) o.next_fetch = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; ins = 16'h1800; ins_valid = 1'b1;
    alu_done = 1'b1; alu_zero = 1'b1;
    tick();
    tick();
    tests_run++; if (out0 !== 25'd0) begin fails++; $display("FAIL reset_outputs got %h want 0", out0); end
    rst = 1'b0; ins_valid = 1'b0; alu_done = 1'b0; alu_zero = 1'b0;
    tick();
    tests_run++; if (fetch_req !== 1'b1) begin fails++; $display("FAIL reset_first_fetch got %b want 1", fetch_req); end
  endtask

  task automatic test_add();
    exp_t e;
    obs_t o;
    sb_q.push_back('{reg_en: 4'b0100, pc: 2'b01, off: 8'h00, func: 3'b000, insel: 1'b0, cycles: 6});
    do_instr(16'h1800, 0, 0, 1'b0, 1'b0, 1'b0, o);
    e = sb_q.pop_front();
    tests_run++; if (o.fetch_c1 !== 1'b1) begin fails++; $display("FAIL add_fetch got %b want 1", o.fetch_c1); end
    tests_run++; if (o.alu_start !== 1'b1) begin fails++; $display("FAIL add_alu_start got %b want 1", o.alu_start); end
    tests_run++; if (o.func !== e.func) begin fails++; $display("FAIL add_func got %b want %b", o.func, e.func); end
    tests_run++; if (o.reg_en !== e.reg_en) begin fails++; $display("FAIL add_reg_en got %b want %b", o.reg_en, e.reg_en); end
    tests_run++; if (o.pulse !== 1'b1 || o.pc !== e.pc) begin fails++; $display("FAIL add_pc got pulse=%b pc=%b want 1/%b", o.pulse, o.pc, e.pc); end
    tests_run++; if (o.cycles !== e.cycles || !o.next_fetch) begin fails++; $display("FAIL add_cycles got %0d (next=%b) want %0d", o.cycles, o.next_fetch, e.cycles); end
  endtask

  task automatic test_branch();
    logic [15:0] words [6];
    bit          zs [6];
    exp_t e;
    obs_t o;
    words = '{16'h2000, 16'h703C, 16'h703C, 16'h2000, 16'h703C, 16'h6012};
    zs    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    sb_q.push_back('{reg_en: 4'b0001, pc: 2'b01, off: 8'h00, func: 3'b001, insel: 1'b0, cycles: 6});
    sb_q.push_back('{reg_en: 4'b0000, pc: 2'b10, off: 8'h3C, func: 3'b000, insel: 1'b0, cycles: 4});
    sb_q.push_back('{reg_en: 4'b0000, pc: 2'b10, off: 8'h3C, func: 3'b000, insel: 1'b0, cycles: 4});
    sb_q.push_back('{reg_en: 4'b0001, pc: 2'b01, off: 8'h00, func: 3'b001, insel: 1'b0, cycles: 6});
    sb_q.push_back('{reg_en: 4'b0000, pc: 2'b01, off: 8'h3C, func: 3'b000, insel: 1'b0, cycles: 4});
    sb_q.push_back('{reg_en: 4'b0000, pc: 2'b10, off: 8'h12, func: 3'b000, insel: 1'b0, cycles: 4});
    for (int k = 0; k < 6; k++) begin
      do_instr(words[k], 0, 0, zs[k], 1'b0, 1'b0, o);
      e = sb_q.pop_front();
      tests_run++; if (o.pc !== e.pc || o.pulse !== 1'b1) begin fails++; $display("FAIL branch%0d_pc got %b want %b", k, o.pc, e.pc); end
      tests_run++; if (o.off !== e.off) begin fails++; $display("FAIL branch%0d_offset got %h want %h", k, o.off, e.off); end
      tests_run++; if (o.reg_en !== e.reg_en || o.func !== e.func) begin fails++; $display("FAIL branch%0d_write got reg_en=%b func=%b want %b/%b", k, o.reg_en, o.func, e.reg_en, e.func); end
      tests_run++; if (o.cycles !== e.cycles) begin fails++; $display("FAIL branch%0d_cycles got %0d want %0d", k, o.cycles, e.cycles); end
    end
  endtask

  task automatic test_waits();
    exp_t e;
    obs_t o;
    sb_q.push_back('{reg_en: 4'b0010, pc: 2'b01, off: 8'h55, func: 3'b100, insel: 1'b1, cycles: 14});
    do_instr(16'h5455, 3, 5, 1'b0, 1'b0, 1'b0, o);
    e = sb_q.pop_front();
    tests_run++; if (o.cycles !== e.cycles) begin fails++; $display("FAIL waits_cycles got %0d want %0d", o.cycles, e.cycles); end
    tests_run++; if (o.stable !== 1'b1) begin fails++; $display("FAIL waits_stable got %b want 1", o.stable); end
    tests_run++; if (o.func !== e.func || o.insel !== e.insel) begin fails++; $display("FAIL waits_ldi_decode got %b/%b want %b/%b", o.func, o.insel, e.func, e.insel); end
    tests_run++; if (o.reg_en !== e.reg_en || o.off !== e.off) begin fails++; $display("FAIL waits_write got %b/%h want %b/%h", o.reg_en, o.off, e.reg_en, e.off); end
  endtask

  task automatic test_strays();
    exp_t e;
    obs_t o;
    sb_q.push_back('{reg_en: 4'b0001, pc: 2'b01, off: 8'h00, func: 3'b001, insel: 1'b0, cycles: 6});
    sb_q.push_back('{reg_en: 4'b0100, pc: 2'b01, off: 8'h00, func: 3'b000, insel: 1'b0, cycles: 9});
    sb_q.push_back('{reg_en: 4'b0000, pc: 2'b10, off: 8'h3C, func: 3'b000, insel: 1'b0, cycles: 6});
    do_instr(16'h2000, 0, 0, 1'b1, 1'b0, 1'b0, o);
    e = sb_q.pop_front();
    tests_run++; if (o.reg_en !== e.reg_en) begin fails++; $display("FAIL stray_sub_reg_en got %b want %b", o.reg_en, e.reg_en); end
    do_instr(16'h1800, 1, 2, 1'b1, 1'b1, 1'b0, o);
    e = sb_q.pop_front();
    tests_run++; if (o.reg_en !== e.reg_en) begin fails++; $display("FAIL stray_ins_valid reg_en got %b want %b", o.reg_en, e.reg_en); end
    tests_run++; if (o.cycles !== e.cycles || o.stable !== 1'b1) begin fails++; $display("FAIL stray_add_timing got %0d stable=%b want %0d", o.cycles, o.stable, e.cycles); end
    do_instr(16'h703C, 2, 0, 1'b0, 1'b1, 1'b0, o);
    e = sb_q.pop_front();
    tests_run++; if (o.pc !== e.pc) begin fails++; $display("FAIL stray_alu_done_z got pc=%b want %b", o.pc, e.pc); end
    tests_run++; if (o.cycles !== e.cycles) begin fails++; $display("FAIL stray_jz_cycles got %0d want %0d", o.cycles, e.cycles); end
  endtask

  task automatic test_illegal();
    obs_t o;
    do_instr(16'h9000, 0, 0, 1'b0, 1'b0, 1'b0, o);
    tests_run++; if (o.illegal_exec !== 1'b1 || o.illegal_after !== 1'b0) begin fails++; $display("FAIL illegal_pulse got exec=%b after=%b want 1/0", o.illegal_exec, o.illegal_after); end
    tests_run++; if (o.pc !== 2'b01 || o.alu_start !== 1'b0) begin fails++; $display("FAIL illegal_as_nop got pc=%b start=%b want 01/0", o.pc, o.alu_start); end
    tests_run++; if (o.cycles !== 4) begin fails++; $display("FAIL illegal_cycles got %0d want 4", o.cycles); end
  endtask

  task automatic test_en_drop();
    obs_t o;
    do_instr(16'h1800, 0, 0, 1'b0, 1'b0, 1'b1, o);
    tests_run++; if (o.reg_en !== 4'b0100 || o.pulse !== 1'b1 || o.pc !== 2'b01) begin fails++; $display("FAIL en_drop_complete got reg_en=%b pulse=%b pc=%b want 0100/1/01", o.reg_en, o.pulse, o.pc); end
    tests_run++; if (o.next_fetch !== 1'b0) begin fails++; $display("FAIL en_drop_idle got next_fetch=%b want 0", o.next_fetch); end
    en = 1'b1;
    tick();
    tests_run++; if (fetch_req !== 1'b1) begin fails++; $display("FAIL en_drop_restart got %b want 1", fetch_req); end
  endtask

  task automatic test_halt();
    obs_t o;
    bit   bad;
    do_instr(16'hF000, 0, 0, 1'b0, 1'b0, 1'b0, o);
    tests_run++; if (o.halted !== 1'b1 || o.alu_start !== 1'b0) begin fails++; $display("FAIL halt_enter got halted=%b start=%b want 1/0", o.halted, o.alu_start); end
    bad = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fetch_req !== 1'b0 || halted !== 1'b1 || en_pc_pulse !== 1'b0) bad = 1'b1;
    end
    tests_run++; if (bad) begin fails++; $display("FAIL halt_hold got activity while halted, want none"); end
    rst = 1'b1;
    tick();
    tests_run++; if (out0 !== 25'd0) begin fails++; $display("FAIL halt_reset got %h want 0", out0); end
    rst = 1'b0;
    en  = 1'b0;
  endtask

  task automatic test_param();
    exp_t e;
    rst1 = 1'b1; en1 = 1'b1; ins1 = '0; ins_valid1 = 1'b0; alu_done1 = 1'b0; alu_zero1 = 1'b0;
    tick();
    tick();
    tests_run++; if (out1 !== 32'd0) begin fails++; $display("FAIL p_reset got %h want 0", out1); end
    rst1 = 1'b0;
    tick();
    tests_run++; if (fetch_req1 !== 1'b1) begin fails++; $display("FAIL p_fetch got %b want 1", fetch_req1); end
    sb_q.push_back('{reg_en: 4'b0000, pc: 2'b01, off: 8'h00, func: 3'b000, insel: 1'b0, cycles: 6});
    tick();
    ins1 = {4'h1, 3'd5, 3'd2, 10'h3A5};
    ins_valid1 = 1'b1;
    tick();
    ins_valid1 = 1'b0;
    tests_run++; if (alu_start1 !== 1'b1 || rs_sel1 !== 3'd2 || offset_addr1 !== 10'h3A5) begin fails++; $display("FAIL p_decode got start=%b rs=%0d off=%h want 1/2/3a5", alu_start1, rs_sel1, offset_addr1); end
    tick();
    alu_done1 = 1'b1;
    tick();
    alu_done1 = 1'b0;
    tests_run++; if (reg_en1 !== 8'b0010_0000) begin fails++; $display("FAIL p_reg_en got %b want 00100000", reg_en1); end
    tick();
    e = sb_q.pop_front();
    tests_run++; if (en_pc_pulse1 !== 1'b1 || pc_ctrl1 !== e.pc) begin fails++; $display("FAIL p_pc got pulse=%b pc=%b want 1/%b", en_pc_pulse1, pc_ctrl1, e.pc); end
    tick();
    tests_run++; if (fetch_req1 !== 1'b1) begin fails++; $display("FAIL p_next_fetch got %b want 1", fetch_req1); end
  endtask

  task automatic test_param_abort();
    tick();
    ins_valid1 = 1'b1;
    tick();
    ins_valid1 = 1'b0;
    tick();
    tests_run++; if (alu_start1 !== 1'b0 || reg_en1 !== 8'd0 || en_pc_pulse1 !== 1'b0) begin fails++; $display("FAIL p_wait_alu got start=%b reg_en=%b pulse=%b want 0/0/0", alu_start1, reg_en1, en_pc_pulse1); end
    rst1 = 1'b1;
    alu_done1 = 1'b1;
    tick();
    tests_run++; if (out1 !== 32'd0) begin fails++; $display("FAIL p_abort_outputs got %h want 0", out1); end
    rst1 = 1'b0;
    tick();
    tests_run++; if (fetch_req1 !== 1'b1 || reg_en1 !== 8'd0 || en_pc_pulse1 !== 1'b0) begin fails++; $display("FAIL p_abort_idle got fetch=%b reg_en=%b pulse=%b want 1/0/0", fetch_req1, reg_en1, en_pc_pulse1); end
    alu_done1 = 1'b0;
    en1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ins = '0; ins_valid = 1'b0; alu_done = 1'b0; alu_zero = 1'b0;
    rst1 = 1'b1; en1 = 1'b0; ins1 = '0; ins_valid1 = 1'b0; alu_done1 = 1'b0; alu_zero1 = 1'b0;
    test_reset();
    test_add();
    test_branch();
    test_waits();
    test_strays();
    test_illegal();
    test_en_drop();
    test_halt();
    test_param();
    test_param_abort();
    if (sb_q.size() != 0) begin
      tests_run++;
      fails++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
